async_gray_fifo: RTL and testbench

//   Parametrised dual-clock FIFO with Gray-coded pointers synchronised across

---
 rtl/async_gray_fifo_if.sv | 34 +++
 rtl/async_gray_fifo.sv | 156 +++++++++++++++
 tb/tb_async_gray_fifo.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_gray_fifo_if.sv
// async_gray_fifo_if: write and read side signals of the dual-clock FIFO.
// master drives requests; slave (the FIFO) returns data and status.
interface async_gray_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   wr_level;
   logic                  overflow;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   rd_level;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, wr_level, overflow,
      input  rd_data, rd_valid, empty, almost_empty,
      input  rd_level, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, wr_level, overflow,
      output rd_data, rd_valid, empty, almost_empty,
      output rd_level, underflow
   );
endinterface

// File: rtl/async_gray_fifo.sv
// async_gray_fifo: dual-clock FIFO, clk1 writes, clk2 reads.
// Only Gray-coded pointers cross domains; all flags are registered.
module async_gray_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input logic              clk1,
   input logic              clk2,
   input logic              reset,
   async_gray_fifo_if.slave bus
);
   localparam int AW    = ADDR_WIDTH;
   localparam int DEPTH = 2 ** AW;

   typedef logic [AW:0] ptr_t;

   localparam ptr_t AFULL_T  = ptr_t'(AFULL_THRESH);
   localparam ptr_t AEMPTY_T = ptr_t'(AEMPTY_THRESH);

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [1:0] r_wrst_sync;
   logic [1:0] r_rrst_sync;
   logic       w_wrst;
   logic       w_rrst;

   // write side state
   ptr_t r_wptr, r_wgray, r_wr_level;
   logic r_full, r_afull, r_overflow;
   logic [SYNC_STAGES-1:0][AW:0] r_rgray_sync;
   logic w_wr_fire, w_full_next;
   ptr_t w_wptr_next, w_wgray_next, w_rgray_s, w_wr_level_next;

   // read side state
   ptr_t r_rptr, r_rgray, r_rd_level;
   logic r_empty, r_aempty, r_underflow, r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [SYNC_STAGES-1:0][AW:0] r_wgray_sync;
   logic w_rd_fire, w_empty_next;
   ptr_t w_rptr_next, w_rgray_next, w_wgray_s, w_rd_level_next;

   // reset asserts at once, releases two clk1 edges later
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) r_wrst_sync <= 2'b11;
      else       r_wrst_sync <= {r_wrst_sync[0], 1'b0};
   end

   // reset asserts at once, releases two clk2 edges later
   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) r_rrst_sync <= 2'b11;
      else       r_rrst_sync <= {r_rrst_sync[0], 1'b0};
   end

   assign w_wrst = r_wrst_sync[1];
   assign w_rrst = r_rrst_sync[1];

   assign w_wr_fire       = bus.wr_en & ~r_full;
   assign w_wptr_next     = r_wptr + ptr_t'(w_wr_fire);
   assign w_wgray_next    = bin2gray(w_wptr_next);
   assign w_rgray_s       = r_rgray_sync[SYNC_STAGES-1];
   assign w_full_next     = w_wgray_next ==
                            {~w_rgray_s[AW:AW-1], w_rgray_s[AW-2:0]};
   assign w_wr_level_next = w_wptr_next - gray2bin(w_rgray_s);

   // store accepted write data; array contents survive reset
   always_ff @(posedge clk1) begin
      if (w_wr_fire) r_mem[r_wptr[AW-1:0]] <= bus.wr_data;
   end

   // bring the read Gray pointer into clk1
   always_ff @(posedge clk1 or posedge w_wrst) begin
      if (w_wrst) r_rgray_sync <= '0;
      else        r_rgray_sync <= {r_rgray_sync[SYNC_STAGES-2:0], r_rgray};
   end

   // write pointer, full/almost_full, level and overflow pulse
   always_ff @(posedge clk1 or posedge w_wrst) begin
      if (w_wrst) begin
         r_wptr     <= '0;
         r_wgray    <= '0;
         r_full     <= 1'b0;
         r_afull    <= 1'b0;
         r_wr_level <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wptr     <= w_wptr_next;
         r_wgray    <= w_wgray_next;
         r_full     <= w_full_next;
         r_afull    <= w_wr_level_next >= AFULL_T;
         r_wr_level <= w_wr_level_next;
         r_overflow <= bus.wr_en & r_full;
      end
   end

   assign w_rd_fire       = bus.rd_en & ~r_empty;
   assign w_rptr_next     = r_rptr + ptr_t'(w_rd_fire);
   assign w_rgray_next    = bin2gray(w_rptr_next);
   assign w_wgray_s       = r_wgray_sync[SYNC_STAGES-1];
   assign w_empty_next    = w_rgray_next == w_wgray_s;
   assign w_rd_level_next = gray2bin(w_wgray_s) - w_rptr_next;

   // bring the write Gray pointer into clk2
   always_ff @(posedge clk2 or posedge w_rrst) begin
      if (w_rrst) r_wgray_sync <= '0;
      else        r_wgray_sync <= {r_wgray_sync[SYNC_STAGES-2:0], r_wgray};
   end

   // read pointer, data register, empty/almost_empty, level, underflow
   always_ff @(posedge clk2 or posedge w_rrst) begin
      if (w_rrst) begin
         r_rptr      <= '0;
         r_rgray     <= '0;
         r_empty     <= 1'b1;
         r_aempty    <= 1'b1;
         r_rd_level  <= '0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_rptr      <= w_rptr_next;
         r_rgray     <= w_rgray_next;
         r_empty     <= w_empty_next;
         r_aempty    <= w_rd_level_next <= AEMPTY_T;
         r_rd_level  <= w_rd_level_next;
         r_underflow <= bus.rd_en & r_empty;
         r_rd_valid  <= w_rd_fire;
         if (w_rd_fire) r_rd_data <= r_mem[r_rptr[AW-1:0]];
      end
   end

   assign bus.full         = r_full;
   assign bus.almost_full  = r_afull;
   assign bus.wr_level     = r_wr_level;
   assign bus.overflow     = r_overflow;
   assign bus.rd_data      = r_rd_data;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.empty        = r_empty;
   assign bus.almost_empty = r_aempty;
   assign bus.rd_level     = r_rd_level;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_async_gray_fifo.sv
// tb_async_gray_fifo: randomized and directed scoreboard bench
// for the dual-clock Gray-pointer FIFO.
module tb_async_gray_fifo;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int SS = 2;

   logic clk1  = 1'b0;
   logic clk2  = 1'b0;
   logic reset = 1'b1;
   int   h1    = 185;
   int   h2    = 185;

   always #(h1) clk1 = ~clk1;
   always #(h2) clk2 = ~clk2;

   async_gray_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   async_gray_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS),
      .AFULL_THRESH(12), .AEMPTY_THRESH(2)
   ) dut (
      .clk1(clk1), .clk2(clk2), .reset(reset), .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_rd_issue = 0;
   int n_rx = 0;
   logic [DW-1:0] exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // expected pulses follow the rules: overflow = wr_en while full,
   // underflow = rd_en while empty, rd_valid = accepted read
   logic exp_ovf, exp_unf, exp_rv;
   always @(posedge clk1 or posedge reset) begin
      if (reset) exp_ovf <= 1'b0;
      else       exp_ovf <= bus.wr_en && bus.full;
   end
   always @(posedge clk2 or posedge reset) begin
      if (reset) begin
         exp_unf <= 1'b0;
         exp_rv  <= 1'b0;
      end else begin
         exp_unf <= bus.rd_en && bus.empty;
         exp_rv  <= bus.rd_en && !bus.empty;
      end
   end

   // write side monitor
   always @(negedge clk1) begin
      if (!reset && (bus.overflow || exp_ovf))
         chk("overflow_pulse", bus.overflow, exp_ovf);
   end

   // read side monitor: pops scoreboard on every rd_valid
   always @(negedge clk2) begin
      if (!reset) begin
         if (bus.underflow || exp_unf)
            chk("underflow_pulse", bus.underflow, exp_unf);
         if (bus.rd_valid || exp_rv)
            chk("rd_valid", bus.rd_valid, exp_rv);
         if (bus.rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               n_rx++;
               chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic wr_cycle(input logic en, input logic [DW-1:0] d);
      @(negedge clk1);
      bus.wr_en   = en;
      bus.wr_data = d;
      if (en && !bus.full) exp_q.push_back(d);
   endtask

   task automatic rd_cycle(input logic en);
      @(negedge clk2);
      bus.rd_en = en;
      if (en && !bus.empty) n_rd_issue++;
   endtask

   task automatic settle();
      fork
         repeat (12) wr_cycle(1'b0, '0);
         repeat (12) rd_cycle(1'b0);
      join
   endtask

   task automatic rand_run(input int nwords);
      int wn;
      int rn;
      wn = 0;
      rn = 0;
      fork
         begin
            int c;
            c = 0;
            while (wn < nwords && c < 20000) begin
               @(negedge clk1);
               c++;
               bus.wr_en   = ($urandom_range(0, 2) != 0) && !bus.full;
               bus.wr_data = DW'($urandom);
               if (bus.wr_en) begin
                  exp_q.push_back(bus.wr_data);
                  wn++;
               end
            end
            @(negedge clk1);
            bus.wr_en = 1'b0;
            if (wn != nwords) chk("wr_timeout", wn, nwords);
         end
         begin
            int c;
            c = 0;
            while (rn < nwords && c < 20000) begin
               @(negedge clk2);
               c++;
               bus.rd_en = ($urandom_range(0, 2) != 0) && !bus.empty;
               if (bus.rd_en) begin
                  rn++;
                  n_rd_issue++;
               end
            end
            @(negedge clk2);
            bus.rd_en = 1'b0;
            if (rn != nwords) chk("rd_timeout", rn, nwords);
         end
      join
   endtask

   initial begin
      #40000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int rx0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      reset       = 1'b1;
      repeat (3) @(negedge clk1);
      reset = 1'b0;
      fork
         repeat (10) @(negedge clk1);
         repeat (10) @(negedge clk2);
      join

      // reset state
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_wr_level", bus.wr_level, 0);
      chk("rst_rd_level", bus.rd_level, 0);
      chk("rst_aempty", bus.almost_empty, 1);
      chk("rst_afull", bus.almost_full, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_underflow", bus.underflow, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);

      // fill to full, overflow, drain, underflow
      h2 = 46;
      settle();
      for (int i = 0; i < 16; i++) begin
         wr_cycle(1'b1, DW'(16 + i));
         if (i == 15) begin
            chk("full_before_16", bus.full, 0);
            chk("wr_level_15", bus.wr_level, 15);
         end
      end
      wr_cycle(1'b1, 8'hAA);
      chk("full_at_16", bus.full, 1);
      chk("wr_level_16", bus.wr_level, 16);
      chk("afull_at_16", bus.almost_full, 1);
      wr_cycle(1'b0, '0);
      chk("overflow_hi", bus.overflow, 1);
      wr_cycle(1'b0, '0);
      chk("overflow_lo", bus.overflow, 0);
      chk("full_held", bus.full, 1);
      repeat (6) rd_cycle(1'b0);
      chk("rd_level_16", bus.rd_level, 16);
      for (int i = 0; i < 16; i++) begin
         rd_cycle(1'b1);
         if (i == 15) begin
            chk("empty_before_last", bus.empty, 0);
            chk("rd_level_1", bus.rd_level, 1);
         end
      end
      rd_cycle(1'b1);
      chk("empty_at_last", bus.empty, 1);
      chk("rd_level_0", bus.rd_level, 0);
      rd_cycle(1'b0);
      chk("underflow_hi", bus.underflow, 1);
      chk("rv_on_underflow", bus.rd_valid, 0);
      chk("rd_data_hold", bus.rd_data, 8'h1F);
      rd_cycle(1'b0);
      chk("underflow_lo", bus.underflow, 0);
      settle();
      chk("full_released", bus.full, 0);

      // single word latency
      h2 = 65;
      settle();
      wr_cycle(1'b1, 8'h5A);
      wr_cycle(1'b0, '0);
      k = 0;
      while (bus.empty && k < SS + 2) begin
         rd_cycle(1'b0);
         k++;
      end
      chk("empty_deassert", bus.empty, 0);
      rd_cycle(1'b1);
      rd_cycle(1'b0);
      chk("single_rv", bus.rd_valid, 1);
      chk("single_data", bus.rd_data, 8'h5A);
      chk("single_empty", bus.empty, 1);

      // almost_full / almost_empty thresholds
      settle();
      for (int i = 0; i < 12; i++) begin
         wr_cycle(1'b1, DW'($urandom));
         if (i == 11) chk("afull_at_11", bus.almost_full, 0);
      end
      wr_cycle(1'b0, '0);
      chk("afull_at_12", bus.almost_full, 1);
      chk("wr_level_12", bus.wr_level, 12);
      settle();
      chk("rd_level_12", bus.rd_level, 12);
      chk("aempty_at_12", bus.almost_empty, 0);
      for (int j = 0; j < 10; j++) begin
         rd_cycle(1'b1);
         if (j == 9) begin
            chk("rd_level_3", bus.rd_level, 3);
            chk("aempty_at_3", bus.almost_empty, 0);
         end
      end
      rd_cycle(1'b0);
      chk("rd_level_2", bus.rd_level, 2);
      chk("aempty_at_2", bus.almost_empty, 1);
      rd_cycle(1'b1);
      rd_cycle(1'b1);
      rd_cycle(1'b0);
      settle();
      chk("drained_empty", bus.empty, 1);

      // random traffic, fast then slow read clock
      h2 = 50;
      rx0 = n_rx;
      rand_run(200);
      settle();
      chk("rand_fast_rx", n_rx - rx0, 200);
      h2 = 617;
      rx0 = n_rx;
      rand_run(200);
      settle();
      chk("rand_slow_rx", n_rx - rx0, 200);

      // reset in the middle of a write burst
      h2 = 46;
      settle();
      for (int i = 0; i < 7; i++) wr_cycle(1'b1, DW'($urandom));
      #20;
      reset = 1'b1;
      #5;
      chk("mid_rst_empty", bus.empty, 1);
      chk("mid_rst_full", bus.full, 0);
      chk("mid_rst_wr_level", bus.wr_level, 0);
      chk("mid_rst_rd_level", bus.rd_level, 0);
      chk("mid_rst_aempty", bus.almost_empty, 1);
      exp_q.delete();
      bus.wr_en = 1'b0;
      #400;
      reset = 1'b0;
      settle();
      chk("post_rst_empty", bus.empty, 1);
      rd_cycle(1'b1);
      rd_cycle(1'b0);
      chk("post_rst_underflow", bus.underflow, 1);
      chk("post_rst_rv", bus.rd_valid, 0);
      chk("post_rst_rd_data", bus.rd_data, 0);
      settle();

      chk("queue_left", exp_q.size(), 0);
      chk("rx_vs_issued", n_rx, n_rd_issue);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
